cube_driver: RTL and testbench

Display-side consumer of the 512-bit `Cells` vector produced by the cube simulator. It snapshots `Cells` at each frame boundary and time-multiplexes the 8×8×8 LED cube one horizontal layer (y) at a time. For each layer it shifts 64 column bits out to a daisy-chained 74HC595-style shift-register chain, latches them, and enables that layer's driver. It sits between the simulator output and the board pins.

---
 rtl/cube_pkg.sv | 22 ++
 rtl/cube_driver_if.sv | 24 ++
 rtl/cube_shift_out.sv | 65 ++++++
 rtl/cube_driver.sv | 124 ++++++++++++
 tb/tb_cube_driver.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cube_pkg.sv
// Shared cube geometry, cell addressing and the display driver's state encoding.
package cube_pkg;
  localparam int WIDTH      = 8;
  localparam int HEIGHT     = 8;
  localparam int DEPTH      = 8;
  localparam int NUM_CELLS  = WIDTH * HEIGHT * DEPTH;
  localparam int LAYER_BITS = WIDTH * DEPTH;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_BLANK,
    ST_LATCH,
    ST_DISPLAY
  } cube_state_e;

  function automatic logic [8:0] cell_index(input logic [2:0] x, input logic [2:0] y,
                                            input logic [2:0] z);
    return 9'(x) + (9'(y) << 3) + (9'(z) << 6);
  endfunction
endpackage

// File: rtl/cube_driver_if.sv
// Bus between the cube simulator output and the LED board pins.
interface cube_driver_if;
  import cube_pkg::*;

  // No valid/ready here: Cells and Enable are levels sampled on every Clk edge;
  // ser_latch and frame_done are single-cycle pulses; ser_data/ser_clk are levels.
  logic [NUM_CELLS-1:0] Cells;
  logic                 Enable;
  logic                 ser_data;
  logic                 ser_clk;
  logic                 ser_latch;
  logic [HEIGHT-1:0]    layer_en;
  logic                 frame_done;

  modport master (
    input  Cells, Enable,
    output ser_data, ser_clk, ser_latch, layer_en, frame_done
  );

  modport slave (
    output Cells, Enable,
    input  ser_data, ser_clk, ser_latch, layer_en, frame_done
  );
endinterface

// File: rtl/cube_shift_out.sv
// Serializes one 64-bit layer word MSB first; each bit is CLK_DIV cycles low then CLK_DIV high.
module cube_shift_out #(
  parameter int CLK_DIV = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        clear,
  input  logic        start,
  input  logic [63:0] word,
  output logic        ser_data,
  output logic        ser_clk,
  output logic        done
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [62:0]      word_q;
  logic [5:0]       bit_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic             busy;
  logic             phase_end;

  assign phase_end = busy && (div_cnt == DIV_LAST);
  // Combinational so the parent leaves SHIFT on the same edge that ends bit 0's high phase.
  assign done      = phase_end && ser_clk && (bit_cnt == 6'd0);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      word_q   <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      busy     <= 1'b0;
      ser_clk  <= 1'b0;
      ser_data <= 1'b0;
    end else if (clear) begin
      div_cnt  <= '0;
      busy     <= 1'b0;
      ser_clk  <= 1'b0;
      ser_data <= 1'b0;
    end else if (start) begin
      word_q   <= word[62:0];
      bit_cnt  <= 6'd63;
      div_cnt  <= '0;
      busy     <= 1'b1;
      ser_clk  <= 1'b0;
      ser_data <= word[63];
    end else if (phase_end) begin
      div_cnt <= '0;
      if (!ser_clk) begin
        ser_clk <= 1'b1;
      end else if (bit_cnt == 6'd0) begin
        busy     <= 1'b0;
        ser_clk  <= 1'b0;
        ser_data <= 1'b0;
      end else begin
        bit_cnt  <= bit_cnt - 6'd1;
        ser_clk  <= 1'b0;
        ser_data <= word_q[62];
        word_q   <= {word_q[61:0], 1'b0};
      end
    end else if (busy) begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end
endmodule

// File: rtl/cube_driver.sv
// Snapshots Cells once per frame and scans the 8x8x8 cube one y-layer at a time via a 74HC595 chain.
module cube_driver
  import cube_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int LAYER_HOLD = 2048
) (
  input  logic          Clk,
  input  logic          Reset,
  cube_driver_if.master bus,
  output cube_state_e   dbg_state
);
  localparam int HOLD_W = (LAYER_HOLD > 1) ? $clog2(LAYER_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(LAYER_HOLD - 1);
  localparam logic [2:0]        LAST_LAYER = 3'(HEIGHT - 1);

  cube_state_e           state;
  logic [NUM_CELLS-1:0]  frame_buf;
  logic [2:0]            layer;
  logic [HOLD_W-1:0]     hold_cnt;
  logic [HEIGHT-1:0]     layer_en;
  logic                  ser_latch;
  logic                  frame_done;
  logic                  hold_last;
  logic                  shift_start;
  logic                  shift_done;
  logic [2:0]            next_layer;
  logic [NUM_CELLS-1:0]  word_src;
  logic [LAYER_BITS-1:0] shift_word;

  assign hold_last   = (hold_cnt == HOLD_LAST);
  assign shift_start = bus.Enable &&
                       ((state == ST_LOAD) ||
                        (state == ST_DISPLAY && hold_last && layer != LAST_LAYER));

  // The serializer captures its word on the edge entering SHIFT, so the word is built for
  // the layer about to be shifted: straight from Cells during LOAD, else from the buffer.
  always_comb begin
    word_src   = (state == ST_LOAD) ? bus.Cells : frame_buf;
    next_layer = (state == ST_LOAD) ? 3'd0 : layer + 3'd1;
    shift_word = '0;
    for (int z = 0; z < DEPTH; z++) begin
      for (int x = 0; x < WIDTH; x++) begin
        shift_word[x + WIDTH * z] = word_src[cell_index(3'(x), next_layer, 3'(z))];
      end
    end
  end

  cube_shift_out #(.CLK_DIV(CLK_DIV)) u_shift (
    .Clk      (Clk),
    .Reset    (Reset),
    .clear    (!bus.Enable),
    .start    (shift_start),
    .word     (shift_word),
    .ser_data (bus.ser_data),
    .ser_clk  (bus.ser_clk),
    .done     (shift_done)
  );

  always_ff @(posedge Clk) begin
    if (state == ST_LOAD && bus.Enable) frame_buf <= bus.Cells;
  end

  // layer_en keeps the previous layer lit through LOAD/SHIFT: the storage registers still hold it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= ST_IDLE;
      layer      <= '0;
      hold_cnt   <= '0;
      layer_en   <= '0;
      ser_latch  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      ser_latch  <= 1'b0;
      frame_done <= 1'b0;
      if (!bus.Enable) begin
        state    <= ST_IDLE;
        layer_en <= '0;
      end else begin
        case (state)
          ST_IDLE: state <= ST_LOAD;
          ST_LOAD: begin
            layer <= '0;
            state <= ST_SHIFT;
          end
          ST_SHIFT: begin
            if (shift_done) begin
              layer_en <= '0;
              state    <= ST_BLANK;
            end
          end
          ST_BLANK: begin
            ser_latch <= 1'b1;
            state     <= ST_LATCH;
          end
          ST_LATCH: begin
            layer_en <= HEIGHT'(1) << layer;
            hold_cnt <= '0;
            state    <= ST_DISPLAY;
          end
          ST_DISPLAY: begin
            if (hold_last) begin
              if (layer == LAST_LAYER) begin
                frame_done <= 1'b1;
                state      <= ST_LOAD;
              end else begin
                layer <= layer + 3'd1;
                state <= ST_SHIFT;
              end
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.layer_en   = layer_en;
  assign bus.ser_latch  = ser_latch;
  assign bus.frame_done = frame_done;
  assign dbg_state      = state;
endmodule

// File: tb/tb_cube_driver.sv
// Directed + randomized bench for cube_driver with a frame-snapshot reference model.
module tb_cube_driver;
  import cube_pkg::*;

  localparam int CLK_DIV     = 2;
  localparam int LAYER_HOLD  = 5;
  localparam int LAYER_P     = 128 * CLK_DIV + 2 + LAYER_HOLD;
  localparam int FRAME       = 1 + 8 * LAYER_P;
  localparam int SMALL_FRAME = 1 + 8 * (128 * 1 + 2 + 4);

  logic        Clk;
  logic        Reset;
  cube_state_e dbg_state;
  cube_state_e dbg_state1;

  cube_driver_if bus ();
  cube_driver_if bus1 ();

  cube_driver #(.CLK_DIV(CLK_DIV), .LAYER_HOLD(LAYER_HOLD)) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus), .dbg_state(dbg_state)
  );

  cube_driver #(.CLK_DIV(1), .LAYER_HOLD(4)) dut_small (
    .Clk(Clk), .Reset(Reset), .bus(bus1), .dbg_state(dbg_state1)
  );

  assign bus1.Enable = bus.Enable;

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  int tests_run = 0;
  int fails     = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: layer y's word bit k = x + 8z comes from cell x + 8y + 64z
  function automatic logic [63:0] model_word(input logic [511:0] c, input int y);
    logic [63:0] w;
    for (int z = 0; z < 8; z++)
      for (int x = 0; x < 8; x++)
        w[x + 8 * z] = c[x + 8 * y + 64 * z];
    return w;
  endfunction

  function automatic logic [511:0] rand_cells();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i * 32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [63:0] outs();
    return 64'({bus.ser_data, bus.ser_clk, bus.ser_latch, bus.layer_en, bus.frame_done});
  endfunction

  // scoreboard / monitor, sampled on the falling edge
  int           cyc = 0;
  int           bit_count = 0;
  int           exp_layer = 0;
  int           last_latch = -1;
  int           last_fd = -1;
  int           load_cyc = -1;
  int           hi_len = 0;
  int           layers_checked = 0;
  logic [63:0]  shift_reg = '0;
  logic [511:0] snap = '0;
  logic         prev_clk = 1'b0;
  logic         prev_data = 1'b0;
  logic         prev_latch = 1'b0;
  logic [7:0]   prev_en = '0;
  logic [63:0]  exp_q[$];

  always @(negedge Clk) begin
    cyc++;
    check("latch_while_lit", 64'(bus.ser_latch && (bus.layer_en != 8'd0)), 64'(0));
    check("layer_en_onehot0", 64'($onehot0(bus.layer_en)), 64'(1));
    if (bus.ser_clk && prev_clk) check("data_stable_high", 64'(bus.ser_data), 64'(prev_data));
    if (Reset || !bus.Enable) begin
      bit_count  = 0;
      exp_layer  = 0;
      last_latch = -1;
      last_fd    = -1;
      load_cyc   = -1;
      hi_len     = 0;
      exp_q.delete();
    end else begin
      if (bus.frame_done) begin
        check("frame_done_after_layer7", 64'(exp_layer), 64'(0));
        if (last_fd >= 0) check("frame_period", 64'(cyc - last_fd), 64'(FRAME));
        last_fd = cyc;
      end
      if (dbg_state == ST_LOAD) begin
        snap      = bus.Cells;
        exp_layer = 0;
        load_cyc  = cyc;
        exp_q.delete();
        for (int y = 0; y < 8; y++) exp_q.push_back(model_word(snap, y));
      end
      if (bus.ser_clk) hi_len++;
      if (!bus.ser_clk && prev_clk) begin
        check("ser_clk_high_len", 64'(hi_len), 64'(CLK_DIV));
        hi_len = 0;
      end
      if (bus.ser_clk && !prev_clk) begin
        if (load_cyc >= 0) begin
          check("first_rise_after_load", 64'(cyc - load_cyc), 64'(CLK_DIV + 1));
          load_cyc = -1;
        end
        shift_reg = {shift_reg[62:0], bus.ser_data};
        bit_count++;
      end
      if (bus.ser_latch) begin
        check("bits_per_layer", 64'(bit_count), 64'(64));
        if (exp_q.size() > 0) check("layer_word", shift_reg, exp_q.pop_front());
        else check("layer_word_expected", 64'(exp_q.size()), 64'(1));
        if (last_latch >= 0)
          check("layer_period", 64'(cyc - last_latch),
                64'((exp_layer == 0) ? LAYER_P + 1 : LAYER_P));
        last_latch = cyc;
        bit_count  = 0;
      end
      if (bus.layer_en != 8'd0 && prev_en == 8'd0) begin
        check("display_after_latch", 64'(prev_latch), 64'(1));
        check("layer_sel", 64'(bus.layer_en), 64'(8'(1) << exp_layer));
        layers_checked++;
        exp_layer = (exp_layer + 1) % 8;
      end
    end
    prev_clk   = bus.ser_clk;
    prev_data  = bus.ser_data;
    prev_latch = bus.ser_latch;
    prev_en    = bus.layer_en;
  end

  // second instance: single lit cell, checks the frame period of the small configuration
  int cyc1 = 0;
  int last_fd1 = -1;
  int small_checks = 0;

  always @(negedge Clk) begin
    cyc1++;
    if (Reset || !bus1.Enable) begin
      last_fd1 = -1;
    end else if (bus1.frame_done) begin
      if (last_fd1 >= 0) begin
        check("small_frame_period", 64'(cyc1 - last_fd1), 64'(SMALL_FRAME));
        small_checks++;
      end
      last_fd1 = cyc1;
    end
  end

  // driver tasks
  task automatic wait_state(input cube_state_e st, input int max_cycles, input string tag);
    int   n;
    logic found;
    n = 0;
    found = 1'b0;
    while (!found && n < max_cycles) begin
      @(posedge Clk); #1;
      n++;
      if (dbg_state == st) found = 1'b1;
    end
    check(tag, 64'(found), 64'(1));
  endtask

  task automatic wait_latches(input int count, input int max_cycles, input string tag);
    int n;
    int seen;
    n = 0;
    seen = 0;
    while (seen < count && n < max_cycles) begin
      @(posedge Clk); #1;
      n++;
      if (bus.ser_latch) seen++;
    end
    check(tag, 64'(seen), 64'(count));
  endtask

  task automatic wait_lit(input int max_cycles, output logic [7:0] en);
    int n;
    n = 0;
    en = '0;
    while (en == 8'd0 && n < max_cycles) begin
      @(posedge Clk); #1;
      n++;
      en = bus.layer_en;
    end
  endtask

  logic [511:0] c;
  logic [511:0] old_cells;
  logic [7:0]   lit;

  initial begin
    Reset = 1'b1;
    bus.Enable = 1'b0;
    bus.Cells = '0;
    bus1.Cells = '0;
    bus1.Cells[0] = 1'b1;
    repeat (3) @(posedge Clk); #1;
    check("reset_outputs", outs(), 64'(0));
    check("reset_state", 64'(dbg_state), 64'(ST_IDLE));

    Reset = 1'b0;
    repeat (3) @(posedge Clk); #1;
    check("disabled_outputs", outs(), 64'(0));
    check("disabled_state", 64'(dbg_state), 64'(ST_IDLE));

    // single cell (0,0,0)
    c = '0;
    c[0] = 1'b1;
    bus.Cells = c;
    bus.Enable = 1'b1;
    @(posedge Clk); #1;
    check("load_after_enable", 64'(dbg_state), 64'(ST_LOAD));
    repeat (2 * FRAME + 20) @(posedge Clk);

    // one full layer, y = 3
    c = '0;
    for (int z = 0; z < 8; z++)
      for (int x = 0; x < 8; x++)
        c[x + 8 * 3 + 64 * z] = 1'b1;
    bus.Cells = c;
    wait_state(ST_LOAD, FRAME + 10, "full_layer_load");
    repeat (FRAME + 5) @(posedge Clk);

    // tear-free update during layer 2 SHIFT
    old_cells = rand_cells();
    bus.Cells = old_cells;
    wait_state(ST_LOAD, FRAME + 10, "tear_load");
    wait_latches(2, 3 * LAYER_P, "tear_two_layers");
    repeat (LAYER_HOLD + 20) @(posedge Clk); #1;
    check("tear_in_shift", 64'(dbg_state), 64'(ST_SHIFT));
    bus.Cells = ~old_cells;
    repeat (2 * FRAME) @(posedge Clk);

    // reset mid-SHIFT
    wait_state(ST_SHIFT, FRAME, "reach_shift");
    repeat (10) @(posedge Clk); #1;
    Reset = 1'b1;
    #1;
    check("async_reset_outputs", outs(), 64'(0));
    check("async_reset_state", 64'(dbg_state), 64'(ST_IDLE));
    repeat (2) @(posedge Clk); #1;
    Reset = 1'b0;
    wait_state(ST_LOAD, 2, "load_after_reset");
    wait_lit(LAYER_P + 10, lit);
    check("first_layer_after_reset", 64'(lit), 64'(8'h01));

    // enable drop during DISPLAY
    wait_state(ST_DISPLAY, LAYER_P + 10, "reach_display");
    bus.Enable = 1'b0;
    @(posedge Clk); #1;
    check("enable_drop_outputs", outs(), 64'(0));
    check("enable_drop_state", 64'(dbg_state), 64'(ST_IDLE));
    bus.Enable = 1'b1;
    @(posedge Clk); #1;
    check("reenable_load", 64'(dbg_state), 64'(ST_LOAD));
    wait_lit(LAYER_P + 10, lit);
    check("first_layer_after_reenable", 64'(lit), 64'(8'h01));

    // random frames
    for (int i = 0; i < 3; i++) begin
      bus.Cells = rand_cells();
      wait_state(ST_LOAD, FRAME + 10, "rand_load");
      repeat (FRAME) @(posedge Clk);
    end

    check("layers_checked_enough", 64'(layers_checked >= 50), 64'(1));
    check("small_periods_checked", 64'(small_checks >= 5), 64'(1));
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
